// File: rtl/movavg_inv.sv
// movavg_inv: recovers the raw sample stream from a TAPS-point moving-sum stream.
// Optional self-check of the recovered stream is enabled with `define MOVAVG_INV_CHECK_EN.
module movavg_inv #(
   parameter int WIDTH = 64,
   parameter int TAPS  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef MOVAVG_INV_CHECK_EN
   ,
   output logic             err_sticky
`endif
);

   generate
      if (TAPS < 2 || TAPS > 8) begin : g_bad_taps
         $error("movavg_inv: TAPS must be in 2..8");
      end
   endgenerate

   logic                       s1_valid;
   logic [WIDTH-1:0]           s1_diff;
   logic [WIDTH-1:0]           yprev;
   logic [TAPS-1:0][WIDTH-1:0] hist;

   logic                       adv1;
   logic                       adv2;
   logic                       take;
   logic [WIDTH-1:0]           x_new;

   // Stall-all chain: stage 1 may only move when stage 2 can accept.
   assign adv2     = !out_valid | out_ready;
   assign adv1     = adv2;
   assign in_ready = !s1_valid | adv1;
   assign take     = in_valid & in_ready;

   // hist[TAPS-1] is x[n-TAPS], the sample leaving the forward window.
   assign x_new = s1_diff + hist[TAPS-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_diff  <= '0;
         yprev    <= '0;
      end else if (take) begin
         s1_valid <= 1'b1;
         s1_diff  <= in_data - yprev;
         yprev    <= in_data;
      end else if (adv1) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         hist      <= '0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         out_data  <= x_new;
         if (s1_valid) begin
            hist[0] <= x_new;
            for (int i = 1; i < TAPS; i++) begin
               hist[i] <= hist[i-1];
            end
         end
      end
   end

`ifdef MOVAVG_INV_CHECK_EN
   logic [WIDTH-1:0] s1_y;
   logic             s2_bad;
   logic [WIDTH-1:0] fwd_sum;

   // Forward filter over the newest sample plus the TAPS-1 most recent history entries.
   always_comb begin
      fwd_sum = x_new;
      for (int i = 0; i < TAPS-1; i++) begin
         fwd_sum = fwd_sum + hist[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_y <= '0;
      end else if (take) begin
         s1_y <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_bad <= 1'b0;
      end else if (adv2) begin
         s2_bad <= s1_valid && (fwd_sum != s1_y);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_sticky <= 1'b0;
      end else if (out_valid && out_ready && s2_bad) begin
         err_sticky <= 1'b1;
      end
   end
`endif

endmodule
